// File: rtl/viterbi_pkg.sv
// Shared types and constants for the K=3, 4-state Viterbi decoder.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam int SYM_W      = 2;
  localparam int PM_W       = 2;

  // Decoding starts from the all-zero encoder state, so it alone gets a zero metric.
  localparam logic [PM_W-1:0] PM0_INIT   = 2'b00;
  localparam logic [PM_W-1:0] PM_X_INIT  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_DECODE,
    ST_DRAIN,
    ST_TB
  } state_e;

  function automatic int step_width(input int steps);
    return (steps > 1) ? $clog2(steps) : 1;
  endfunction

endpackage

// File: rtl/vit_delay_line.sv
// Valid/data shift register of DEPTH stages with a synchronous flush.
module vit_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             flush_i,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic [DEPTH-1:0] vld_q;
  logic [WIDTH-1:0] data_q [DEPTH];

  // NOTE: the data stages are reset as well, because the write address is a
  // visible output that must read 0 out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else if (flush_i) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      vld_q[0]  <= valid_i;
      data_q[0] <= data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        data_q[i] <= data_q[i-1];
      end
    end
  end

  assign valid_o = vld_q[DEPTH-1];
  assign data_o  = data_q[DEPTH-1];

endmodule

// File: rtl/viterbi_frame_ctrl.sv
// Frame sequencer: symbol intake, PM init, survivor write strobes, traceback launch.
module viterbi_frame_ctrl
  import viterbi_pkg::*;
#(
  parameter  int FRAME_LEN = 16,
  parameter  int TAIL_LEN  = 2,
  parameter  int ACS_LAT   = 1,
  localparam int STEPS     = FRAME_LEN + TAIL_LEN,
  localparam int STEP_W    = step_width(STEPS)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_abort,
  input  logic              i_sym_valid,
  input  logic [SYM_W-1:0]  i_sym,
  output logic              o_sym_ready,
  output logic              o_pm_init,
  output logic              o_step_valid,
  output logic [SYM_W-1:0]  o_step_sym,
  output logic [STEP_W-1:0] o_step_idx,
  output logic              o_sm_we,
  output logic [STEP_W-1:0] o_sm_waddr,
  output logic              o_tb_start,
  output logic [STEP_W-1:0] o_tb_addr,
  input  logic              i_tb_done,
  output logic              o_busy,
  output logic              o_frame_done,
  output logic              o_aborted
);

  localparam logic [STEP_W-1:0] LAST = STEP_W'(STEPS - 1);

  state_e            state_q, state_d;
  logic [STEP_W-1:0] cnt_q, cnt_d;
  logic              step_valid_q, tb_start_q, frame_done_q, aborted_q;
  logic [SYM_W-1:0]  step_sym_q;
  logic [STEP_W-1:0] step_idx_q;
  logic              sym_hs, abort_req, tb_done_ok;

  assign sym_hs     = i_sym_valid & o_sym_ready;
  assign abort_req  = i_abort & (state_q != ST_IDLE);
  // The launch cycle itself cannot complete a traceback that has not started.
  assign tb_done_ok = i_tb_done & ~tb_start_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it unassigned.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (i_start) state_d = ST_INIT;
      ST_INIT:   state_d = ST_DECODE;
      ST_DECODE: if (sym_hs && cnt_q == LAST) state_d = ST_DRAIN;
      ST_DRAIN:  if (o_sm_we && o_sm_waddr == LAST) state_d = ST_TB;
      ST_TB:     if (tb_done_ok) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (abort_req) state_d = ST_IDLE;
  end

  always_comb begin
    o_sym_ready = (state_q == ST_DECODE);
    o_pm_init   = (state_q == ST_INIT);
    o_busy      = (state_q != ST_IDLE);
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == ST_INIT)              cnt_d = '0;
    else if (sym_hs && cnt_q != LAST)    cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q        <= '0;
      step_valid_q <= 1'b0;
      step_sym_q   <= '0;
      step_idx_q   <= '0;
      tb_start_q   <= 1'b0;
      frame_done_q <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      step_valid_q <= sym_hs & ~abort_req;
      if (sym_hs && !abort_req) begin
        step_sym_q <= i_sym;
        step_idx_q <= cnt_q;
      end
      tb_start_q   <= (state_q == ST_DRAIN) && (state_d == ST_TB);
      frame_done_q <= (state_q == ST_TB) && tb_done_ok && !i_abort;
      aborted_q    <= abort_req;
    end
  end

  vit_delay_line #(
    .DEPTH (ACS_LAT),
    .WIDTH (STEP_W)
  ) u_sm_delay (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .flush_i (abort_req),
    .valid_i (step_valid_q),
    .data_i  (step_idx_q),
    .valid_o (o_sm_we),
    .data_o  (o_sm_waddr)
  );

  assign o_step_valid = step_valid_q;
  assign o_step_sym   = step_sym_q;
  assign o_step_idx   = step_idx_q;
  assign o_tb_start   = tb_start_q;
  assign o_tb_addr    = LAST;
  assign o_frame_done = frame_done_q;
  assign o_aborted    = aborted_q;

endmodule

// File: tb/tb_viterbi_frame_ctrl.sv
// Directed, table-driven bench for viterbi_frame_ctrl (FRAME_LEN=4, TAIL_LEN=2, ACS_LAT=1).
module tb_viterbi_frame_ctrl;

  logic       i_clk = 1'b0;
  logic       i_rst_n = 1'b0;
  logic       i_start = 1'b0, i_abort = 1'b0, i_sym_valid = 1'b0, i_tb_done = 1'b0;
  logic [1:0] i_sym = 2'b00;
  logic       o_sym_ready, o_pm_init, o_step_valid, o_sm_we, o_tb_start;
  logic       o_busy, o_frame_done, o_aborted;
  logic [1:0] o_step_sym;
  logic [2:0] o_step_idx, o_sm_waddr, o_tb_addr;

  int n_tests = 0;
  int n_fail  = 0;

  viterbi_frame_ctrl #(.FRAME_LEN(4), .TAIL_LEN(2), .ACS_LAT(1)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_sym_valid(i_sym_valid), .i_sym(i_sym), .o_sym_ready(o_sym_ready),
    .o_pm_init(o_pm_init), .o_step_valid(o_step_valid), .o_step_sym(o_step_sym),
    .o_step_idx(o_step_idx), .o_sm_we(o_sm_we), .o_sm_waddr(o_sm_waddr),
    .o_tb_start(o_tb_start), .o_tb_addr(o_tb_addr), .i_tb_done(i_tb_done),
    .o_busy(o_busy), .o_frame_done(o_frame_done), .o_aborted(o_aborted)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       start, abort, vld;
    logic [1:0] sym;
    logic       done;
    logic       rdy, init, sv;
    logic [1:0] ssym;
    logic [2:0] sidx;
    logic       we;
    logic [2:0] wa;
    logic       tbs, busy, fd, ab;
  } vec_t;

  vec_t vq[$];

  // {rdy, init, sv, ssym, sidx, we, wa, tbs, busy, fd, ab}
  function automatic logic [15:0] outs();
    return {o_sym_ready, o_pm_init, o_step_valid, o_step_sym, o_step_idx,
            o_sm_we, o_sm_waddr, o_tb_start, o_busy, o_frame_done, o_aborted};
  endfunction

  function automatic logic [15:0] exp_of(input vec_t v);
    return {v.rdy, v.init, v.sv, v.ssym, v.sidx, v.we, v.wa, v.tbs, v.busy, v.fd, v.ab};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic drive(input logic st, ab, vl, input logic [1:0] sy, input logic dn);
    i_start = st; i_abort = ab; i_sym_valid = vl; i_sym = sy; i_tb_done = dn;
  endtask

  task automatic cyc(input logic st, ab, vl, input logic [1:0] sy, input logic dn);
    drive(st, ab, vl, sy, dn);
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int we_cnt, tbs_cnt, ab_cnt, sv_cnt, fd_cnt;

    // Frame 1: 6 symbols back-to-back, tb_done 3 cycles after launch, restart on frame_done.
    vq.push_back('{1,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0});
    vq.push_back('{0,0,0,0,0, 0,1,0,0,0,0,0,0,1,0,0});
    vq.push_back('{0,0,1,1,0, 1,0,0,0,0,0,0,0,1,0,0});
    vq.push_back('{0,0,1,2,0, 1,0,1,1,0,0,0,0,1,0,0});
    vq.push_back('{0,0,1,3,0, 1,0,1,2,1,1,0,0,1,0,0});
    vq.push_back('{0,0,1,0,0, 1,0,1,3,2,1,1,0,1,0,0});
    vq.push_back('{0,0,1,1,0, 1,0,1,0,3,1,2,0,1,0,0});
    vq.push_back('{0,0,1,2,0, 1,0,1,1,4,1,3,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 0,0,1,2,5,1,4,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 0,0,0,2,5,1,5,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 0,0,0,2,5,0,5,1,1,0,0});
    vq.push_back('{0,0,0,0,0, 0,0,0,2,5,0,5,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 0,0,0,2,5,0,5,0,1,0,0});
    vq.push_back('{0,0,0,0,1, 0,0,0,2,5,0,5,0,1,0,0});
    vq.push_back('{1,0,0,0,0, 0,0,0,2,5,0,5,0,0,1,0});
    vq.push_back('{0,0,0,0,0, 0,1,0,2,5,0,5,0,1,0,0});
    // Frame 2: valid pattern 1,0,0 with a stray start in DECODE and tb_done on the launch cycle.
    vq.push_back('{0,0,1,1,0, 1,0,0,2,5,0,5,0,1,0,0});
    vq.push_back('{1,0,0,0,0, 1,0,1,1,0,0,5,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 1,0,0,1,0,1,0,0,1,0,0});
    vq.push_back('{0,0,1,2,0, 1,0,0,1,0,0,0,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 1,0,1,2,1,0,0,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 1,0,0,2,1,1,1,0,1,0,0});
    vq.push_back('{0,0,1,3,0, 1,0,0,2,1,0,1,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 1,0,1,3,2,0,1,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 1,0,0,3,2,1,2,0,1,0,0});
    vq.push_back('{0,0,1,0,0, 1,0,0,3,2,0,2,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 1,0,1,0,3,0,2,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 1,0,0,0,3,1,3,0,1,0,0});
    vq.push_back('{0,0,1,1,0, 1,0,0,0,3,0,3,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 1,0,1,1,4,0,3,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 1,0,0,1,4,1,4,0,1,0,0});
    vq.push_back('{0,0,1,2,0, 1,0,0,1,4,0,4,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 0,0,1,2,5,0,4,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 0,0,0,2,5,1,5,0,1,0,0});
    vq.push_back('{0,0,0,0,1, 0,0,0,2,5,0,5,1,1,0,0});
    vq.push_back('{0,0,0,0,1, 0,0,0,2,5,0,5,0,1,0,0});
    vq.push_back('{0,0,0,0,0, 0,0,0,2,5,0,5,0,0,1,0});
    vq.push_back('{0,0,0,0,0, 0,0,0,2,5,0,5,0,0,0,0});

    #12;
    check("reset_outs", outs(), 16'h0000);
    check("reset_tb_addr", {13'd0, o_tb_addr}, 16'd5);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    foreach (vq[i]) begin
      drive(vq[i].start, vq[i].abort, vq[i].vld, vq[i].sym, vq[i].done);
      check($sformatf("row%0d", i), outs(), exp_of(vq[i]));
      @(posedge i_clk);
      #1;
    end
    drive(0, 0, 0, 0, 0);

    // Abort in DECODE right after the third handshake.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 0, 1, 2, 0);
    cyc(0, 0, 1, 3, 0);
    cyc(0, 1, 0, 0, 0);
    check("abort_pulse", {15'd0, o_aborted}, 16'd1);
    check("abort_busy", {15'd0, o_busy}, 16'd0);
    we_cnt = 0; tbs_cnt = 0; ab_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      we_cnt  += int'(o_sm_we);
      tbs_cnt += int'(o_tb_start);
      ab_cnt  += int'(o_aborted);
      cyc(0, 0, 0, 0, 0);
    end
    check("abort_no_we", 16'(we_cnt), 16'd0);
    check("abort_no_tbs", 16'(tbs_cnt), 16'd0);
    check("abort_once", 16'(ab_cnt), 16'd1);

    // Abort in the same cycle as a handshake.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0);
    cyc(0, 1, 1, 2, 0);
    check("abort_hs_state", {o_step_valid, o_aborted, o_busy, o_sym_ready}, 16'b0100);
    sv_cnt = 0;
    for (int k = 0; k < 4; k++) begin
      sv_cnt += int'(o_step_valid);
      cyc(0, 0, 1, 3, 0);
    end
    check("abort_hs_no_sv", 16'(sv_cnt), 16'd0);

    // Reset while waiting for traceback completion.
    cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) cyc(0, 0, 1, 2'(k), 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    check("pre_rst_tbs", {15'd0, o_tb_start}, 16'd1);
    cyc(0, 0, 0, 0, 0);
    #2;
    i_rst_n = 1'b0;
    #1;
    check("rst_mid_tb_outs", outs(), 16'h0000);
    check("rst_mid_tb_addr", {13'd0, o_tb_addr}, 16'd5);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    fd_cnt = 0;
    cyc(0, 0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin
      fd_cnt += int'(o_frame_done) + int'(o_busy);
      cyc(0, 0, 0, 0, 0);
    end
    check("late_tb_done", 16'(fd_cnt), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
